// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a start/busy/done handshake.
//   Single-cycle ops: ADD, SUB, AND, ORR, EOR, and the reserved opcode.
//   Iterative ops: MUL (shift-add) and, when ALU_MC_DIV_EN is defined,
//   UDIV (restoring division). Each iterative op takes WIDTH cycles.
//   Without ALU_MC_DIV_EN, UDIV completes in one cycle with result 0.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request; accepted only while busy == 0
//   ALUControl      opcode (000 ADD, 001 SUB, 010 AND, 011 ORR,
//                   100 MUL, 101 UDIV, 110 EOR, 111 reserved)
//   SrcA, SrcB      operands; latched when the request is accepted
//   ALUResult       registered result; holds until the next completion
//   ALUFlags        registered {N,Z,C,V}; holds until the next completion
//   busy            high while MUL/UDIV iterates
//   done            one-cycle completion pulse
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned W1 = WIDTH + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_EOR  = 3'b110;
`ifdef ALU_MC_DIV_EN
    localparam logic [2:0] OP_UDIV = 3'b101;
`endif

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;      // multiplicand / dividend-then-quotient
    logic [WIDTH-1:0] b_q, b_d;      // multiplier / divisor
    logic [WIDTH-1:0] acc_q, acc_d;  // product accumulator / partial remainder
    logic [WIDTH-1:0] result_d;
    logic [3:0]       flags_d;
    logic             busy_d, done_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_result;
    logic             sc_c, sc_v;
    logic             iter_op_c;

    logic [WIDTH-1:0] it_a, it_b, it_acc, it_result;

`ifdef ALU_MC_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   rem_sh, diff;
`endif

    // Single-cycle datapath; SUB is A + ~B + 1 so C means "no borrow".
    always_comb begin
        sum       = {1'b0, SrcA} + {1'b0, (ALUControl[0] ? ~SrcB : SrcB)}
                    + W1'(ALUControl[0]);
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                sc_result = sum[WIDTH-1:0];
                sc_c      = sum[WIDTH];
                sc_v      = ~(SrcA[WIDTH-1] ^ SrcB[WIDTH-1] ^ ALUControl[0])
                            & (SrcA[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND:  sc_result = SrcA & SrcB;
            OP_ORR:  sc_result = SrcA | SrcB;
            OP_EOR:  sc_result = SrcA ^ SrcB;
            default: sc_result = '0;  // reserved, and UDIV when no divider
        endcase
    end

    // Which opcodes enter the iterative state.
    always_comb begin
        iter_op_c = (ALUControl == OP_MUL);
`ifdef ALU_MC_DIV_EN
        if (ALUControl == OP_UDIV) begin
            iter_op_c = 1'b1;
        end
`endif
    end

    // One iteration step of the multiplier or the divider.
    always_comb begin
        it_acc    = acc_q + (b_q[0] ? a_q : '0);
        it_a      = a_q << 1;
        it_b      = b_q >> 1;
        it_result = it_acc;
`ifdef ALU_MC_DIV_EN
        rem_sh = {acc_q, a_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (div_q) begin
            // Restore on borrow; quotient bits shift in where the dividend leaves.
            it_acc    = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            it_a      = {a_q[WIDTH-2:0], ~diff[WIDTH]};
            it_b      = b_q;
            it_result = (b_q == '0) ? '0 : it_a;
        end
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = ALUResult;
        flags_d  = ALUFlags;
        busy_d   = busy;
        done_d   = 1'b0;
`ifdef ALU_MC_DIV_EN
        div_d    = div_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (iter_op_c) begin
                        a_d     = SrcA;
                        b_d     = SrcB;
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = S_CALC;
`ifdef ALU_MC_DIV_EN
                        div_d   = (ALUControl == OP_UDIV);
`endif
                    end else begin
                        result_d = sc_result;
                        flags_d  = {sc_result[WIDTH-1], ~|sc_result, sc_c, sc_v};
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                a_d   = it_a;
                b_d   = it_b;
                acc_d = it_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = it_result;
                    flags_d  = {it_result[WIDTH-1], ~|it_result, 2'b00};
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            ALUResult <= '0;
            ALUFlags  <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            ALUResult <= result_d;
            ALUFlags  <= flags_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef ALU_MC_DIV_EN
            div_q     <= div_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: a WIDTH=32 and a WIDTH=8 instance share clock and reset.
// Expected values come from directed constants and an arithmetic reference model.
module tb_alu_mc;

`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] MUL  = 3'd4;
    localparam logic [2:0] UDIV = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0;
    logic [2:0]  op32 = 3'd0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] res32;
    logic [3:0]  flg32;
    logic        busy32, done32;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  res8;
    logic [3:0]  flg8;
    logic        busy8, done8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .ALUControl(op32),
        .SrcA(a32), .SrcB(b32), .ALUResult(res32), .ALUFlags(flg32),
        .busy(busy32), .done(done32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUControl(op8),
        .SrcA(a8), .SrcB(b8), .ALUResult(res8), .ALUFlags(flg8),
        .busy(busy8), .done(done8)
    );

    // Reference: {N,Z,C,V, result} computed from the arithmetic rules.
    function automatic logic [67:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, r, s;
        logic am, bm, rm, c, v;
        mask = (64'd1 << w) - 64'd1;
        r = '0; c = 1'b0; v = 1'b0;
        am = a[w-1];
        bm = b[w-1];
        case (op)
            3'd0: begin s = a + b; r = s & mask; c = s[w]; end
            3'd1: begin r = (a - b) & mask; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = (a * b) & mask;
            3'd5: r = (DIV_EN && b != 64'd0) ? a / b : 64'd0;
            3'd6: r = a ^ b;
            default: r = '0;
        endcase
        rm = r[w-1];
        if (op == 3'd0) v = (am == bm) && (rm != am);
        if (op == 3'd1) v = (am != bm) && (rm != am);
        return {rm, (r == 64'd0), c, v, r};
    endfunction

    function automatic int exp_lat(input int w, input logic [2:0] op);
        if (op == MUL || (op == UDIV && DIV_EN)) return w + 1;
        return 1;
    endfunction

    // Issue one op on the 32-bit instance; report result, latency, busy cycles
    // and whether the outputs stayed put until completion.
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f, output int lat,
                         output int bcnt, output bit stable);
        logic [31:0] pr;
        logic [3:0]  pf;
        @(negedge clk);
        pr = res32; pf = flg32;
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        lat = -1; bcnt = 0; stable = 1'b1; r = 'x; f = 'x;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start32 = 1'b0;
            a32 = $urandom; b32 = $urandom;   // operands must already be latched
            if (busy32) bcnt++;
            if (done32) begin lat = n; r = res32; f = flg32; break; end
            if (res32 !== pr || flg32 !== pf) stable = 1'b0;
        end
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic [3:0] f, output int lat,
                        output int bcnt);
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        lat = -1; bcnt = 0; r = 'x; f = 'x;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            if (busy8) bcnt++;
            if (done8) begin lat = n; r = res8; f = flg8; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total += 8;
        if (res32 !== 32'h0) begin bad++; $display("FAIL reset_res32 got %h want 0", res32); end
        if (flg32 !== 4'h0)  begin bad++; $display("FAIL reset_flg32 got %b want 0000", flg32); end
        if (busy32 !== 1'b0) begin bad++; $display("FAIL reset_busy32 got %b want 0", busy32); end
        if (done32 !== 1'b0) begin bad++; $display("FAIL reset_done32 got %b want 0", done32); end
        if (res8 !== 8'h0)   begin bad++; $display("FAIL reset_res8 got %h want 0", res8); end
        if (flg8 !== 4'h0)   begin bad++; $display("FAIL reset_flg8 got %b want 0000", flg8); end
        if (busy8 !== 1'b0)  begin bad++; $display("FAIL reset_busy8 got %b want 0", busy8); end
        if (done8 !== 1'b0)  begin bad++; $display("FAIL reset_done8 got %b want 0", done8); end
        reset = 1'b0;
    endtask

    task automatic test_directed32;
        logic [31:0] r; logic [3:0] f; int lat, bc; bit st;

        run32(ADD, 32'h7FFFFFFF, 32'h1, r, f, lat, bc, st);
        total += 4;
        if (r !== 32'h80000000) begin bad++; $display("FAIL add_ovf_res got %h want 80000000", r); end
        if (f !== 4'b1001)      begin bad++; $display("FAIL add_ovf_flags got %b want 1001", f); end
        if (lat !== 1)          begin bad++; $display("FAIL add_ovf_lat got %0d want 1", lat); end
        if (bc !== 0)           begin bad++; $display("FAIL add_ovf_busy got %0d want 0", bc); end

        run32(SUB, 32'd5, 32'd5, r, f, lat, bc, st);
        total += 2;
        if (r !== 32'h0)   begin bad++; $display("FAIL sub_eq_res got %h want 0", r); end
        if (f !== 4'b0110) begin bad++; $display("FAIL sub_eq_flags got %b want 0110", f); end

        run32(SUB, 32'd3, 32'd5, r, f, lat, bc, st);
        total += 2;
        if (r !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub_neg_res got %h want fffffffe", r); end
        if (f !== 4'b1000)      begin bad++; $display("FAIL sub_neg_flags got %b want 1000", f); end

        run32(MUL, 32'd7, 32'd6, r, f, lat, bc, st);
        total += 5;
        if (r !== 32'h2A)  begin bad++; $display("FAIL mul_7x6_res got %h want 2a", r); end
        if (f !== 4'b0000) begin bad++; $display("FAIL mul_7x6_flags got %b want 0000", f); end
        if (lat !== 33)    begin bad++; $display("FAIL mul_7x6_lat got %0d want 33", lat); end
        if (bc !== 32)     begin bad++; $display("FAIL mul_7x6_busy got %0d want 32", bc); end
        if (st !== 1'b1)   begin bad++; $display("FAIL mul_7x6_hold got %b want 1", st); end

        run32(MUL, 32'h00010000, 32'h00010000, r, f, lat, bc, st);
        total += 2;
        if (r !== 32'h0)   begin bad++; $display("FAIL mul_wrap_res got %h want 0", r); end
        if (f !== 4'b0100) begin bad++; $display("FAIL mul_wrap_flags got %b want 0100", f); end

        run32(UDIV, 32'd100, 32'd7, r, f, lat, bc, st);
        total += 3;
`ifdef ALU_MC_DIV_EN
        if (r !== 32'd14)  begin bad++; $display("FAIL udiv_100_7_res got %h want e", r); end
        if (f !== 4'b0000) begin bad++; $display("FAIL udiv_100_7_flags got %b want 0000", f); end
        if (lat !== 33)    begin bad++; $display("FAIL udiv_100_7_lat got %0d want 33", lat); end
        run32(UDIV, 32'd9, 32'd0, r, f, lat, bc, st);
        total += 2;
        if (r !== 32'h0)   begin bad++; $display("FAIL udiv_by0_res got %h want 0", r); end
        if (f !== 4'b0100) begin bad++; $display("FAIL udiv_by0_flags got %b want 0100", f); end
`else
        if (r !== 32'h0)   begin bad++; $display("FAIL udiv_off_res got %h want 0", r); end
        if (f !== 4'b0100) begin bad++; $display("FAIL udiv_off_flags got %b want 0100", f); end
        if (lat !== 1)     begin bad++; $display("FAIL udiv_off_lat got %0d want 1", lat); end
        total += 1;
        if (bc !== 0)      begin bad++; $display("FAIL udiv_off_busy got %0d want 0", bc); end
`endif
    endtask

    task automatic test_random32;
        logic [31:0] r, a, b; logic [3:0] f; logic [2:0] op; logic [67:0] e;
        int lat, bc; bit st;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            e  = ref_model(32, op, 64'(a), 64'(b));
            run32(op, a, b, r, f, lat, bc, st);
            total += 3;
            if (r !== e[31:0]) begin bad++;
                $display("FAIL rand32_res op=%0d a=%h b=%h got %h want %h", op, a, b, r, e[31:0]); end
            if (f !== e[67:64]) begin bad++;
                $display("FAIL rand32_flags op=%0d a=%h b=%h got %b want %b", op, a, b, f, e[67:64]); end
            if (lat !== exp_lat(32, op)) begin bad++;
                $display("FAIL rand32_lat op=%0d got %0d want %0d", op, lat, exp_lat(32, op)); end
        end
    endtask

    task automatic test_width8;
        logic [7:0] r, a, b; logic [3:0] f; logic [2:0] op; logic [67:0] e; int lat, bc;

        run8(ADD, 8'hFF, 8'h01, r, f, lat, bc);
        total += 3;
        if (r !== 8'h00)   begin bad++; $display("FAIL w8_add_res got %h want 00", r); end
        if (f !== 4'b0110) begin bad++; $display("FAIL w8_add_flags got %b want 0110", f); end
        if (lat !== 1)     begin bad++; $display("FAIL w8_add_lat got %0d want 1", lat); end

        run8(MUL, 8'h10, 8'h10, r, f, lat, bc);
        total += 4;
        if (r !== 8'h00)   begin bad++; $display("FAIL w8_mul_res got %h want 00", r); end
        if (f !== 4'b0100) begin bad++; $display("FAIL w8_mul_flags got %b want 0100", f); end
        if (lat !== 9)     begin bad++; $display("FAIL w8_mul_lat got %0d want 9", lat); end
        if (bc !== 8)      begin bad++; $display("FAIL w8_mul_busy got %0d want 8", bc); end

        for (int i = 0; i < 25; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            e  = ref_model(8, op, 64'(a), 64'(b));
            run8(op, a, b, r, f, lat, bc);
            total += 3;
            if (r !== e[7:0]) begin bad++;
                $display("FAIL rand8_res op=%0d a=%h b=%h got %h want %h", op, a, b, r, e[7:0]); end
            if (f !== e[67:64]) begin bad++;
                $display("FAIL rand8_flags op=%0d a=%h b=%h got %b want %b", op, a, b, f, e[67:64]); end
            if (lat !== exp_lat(8, op)) begin bad++;
                $display("FAIL rand8_lat op=%0d got %0d want %0d", op, lat, exp_lat(8, op)); end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        start32 = 1'b1; op32 = ADD; a32 = 32'd2; b32 = 32'd3;
        @(negedge clk);
        total += 2;
        if (done32 !== 1'b1) begin bad++; $display("FAIL b2b_add_done got %b want 1", done32); end
        if (res32 !== 32'd5) begin bad++; $display("FAIL b2b_add_res got %h want 5", res32); end
        op32 = SUB; a32 = 32'd10; b32 = 32'd4;
        @(negedge clk);
        total += 2;
        if (done32 !== 1'b1) begin bad++; $display("FAIL b2b_sub_done got %b want 1", done32); end
        if (res32 !== 32'd6) begin bad++; $display("FAIL b2b_sub_res got %h want 6", res32); end
        op32 = MUL; a32 = 32'd5; b32 = 32'd5;
        @(negedge clk);
        start32 = 1'b0;
        n = 1;
        while (done32 !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        total += 2;
        if (n !== 33)         begin bad++; $display("FAIL b2b_mul_lat got %0d want 33", n); end
        if (res32 !== 32'd25) begin bad++; $display("FAIL b2b_mul_res got %h want 19", res32); end
        // New request in the done cycle of the multiply.
        start32 = 1'b1; op32 = ADD; a32 = 32'd7; b32 = 32'd8;
        @(negedge clk);
        start32 = 1'b0;
        total += 2;
        if (done32 !== 1'b1)  begin bad++; $display("FAIL b2b_after_mul_done got %b want 1", done32); end
        if (res32 !== 32'd15) begin bad++; $display("FAIL b2b_after_mul_res got %h want f", res32); end
    endtask

    task automatic test_ignore_start;
        int dcount, dn;
        logic [31:0] r; logic [3:0] f;
        @(negedge clk);
        start32 = 1'b1; op32 = MUL; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk);
        dcount = 0; dn = -1; r = 'x; f = 'x;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 5) begin start32 = 1'b1; op32 = ADD; a32 = 32'd1; b32 = 32'd1; end
            else start32 = 1'b0;
            if (done32) begin
                dcount++;
                if (dn < 0) begin dn = n; r = res32; f = flg32; end
            end
        end
        total += 5;
        if (dcount !== 1)     begin bad++; $display("FAIL ignore_done_count got %0d want 1", dcount); end
        if (dn !== 33)        begin bad++; $display("FAIL ignore_lat got %0d want 33", dn); end
        if (r !== 32'd12)     begin bad++; $display("FAIL ignore_res got %h want c", r); end
        if (f !== 4'b0000)    begin bad++; $display("FAIL ignore_flags got %b want 0000", f); end
        if (res32 !== 32'd12) begin bad++; $display("FAIL ignore_res_after got %h want c", res32); end
    endtask

    task automatic test_reset_abort;
        int dcount;
        @(negedge clk);
        start32 = 1'b1; op32 = MUL; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (n == 10) reset = 1'b1;
        end
        @(negedge clk);
        total += 4;
        if (res32 !== 32'h0)  begin bad++; $display("FAIL abort_res got %h want 0", res32); end
        if (flg32 !== 4'h0)   begin bad++; $display("FAIL abort_flags got %b want 0000", flg32); end
        if (busy32 !== 1'b0)  begin bad++; $display("FAIL abort_busy got %b want 0", busy32); end
        if (done32 !== 1'b0)  begin bad++; $display("FAIL abort_done got %b want 0", done32); end
        reset = 1'b0;
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done32 || busy32) dcount++;
        end
        total += 1;
        if (dcount !== 0) begin bad++; $display("FAIL abort_quiet got %0d want 0", dcount); end
    endtask

    initial begin
        test_reset();
        test_directed32();
        test_random32();
        test_width8();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
